// File: rtl/clock_alarm_ctrl_pkg.sv
// Shared state encoding, BCD constants and the BCD time check used by the
// alarm controller and the clock set path.
package clock_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_59 = 8'h59;

  // A 12-hour BCD time is valid when every nibble is a decimal digit,
  // the hour is 01-12 and the minute is 00-59.
  function automatic logic bcd_time_valid(input logic [7:0] h, input logic [7:0] m);
    logic digits_ok;
    digits_ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
                (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9);
    return digits_ok && (h >= BCD_01) && (h <= BCD_12) && (m <= BCD_59);
  endfunction

endpackage

// File: rtl/clock_alarm_ctrl_timer.sv
// Loadable down-counter for ring and snooze durations. Advances only on the
// one-second tick and never counts below 1; flags the tick that sees 1.
module clock_alarm_ctrl_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && ena && (count > WIDTH'(1))) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = ena && (count == WIDTH'(1));

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm stage: stores the alarm time, detects the minute it is reached and
// runs the ring / snooze / dismiss state machine.
module clock_alarm_ctrl
  import clock_alarm_ctrl_pkg::*;
#(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 9,
  parameter int SNOOZE_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       arm,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic       snoozing,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_pm,
  output logic [2:0] snooze_left
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int TIMER_MAX    = (RING_SECS > SNOOZE_TICKS) ? RING_SECS : SNOOZE_TICKS;
  localparam int TW           = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] RING_LOAD   = TW'(RING_SECS);
  localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_TICKS);
  localparam logic [2:0]    SNZ_RELOAD  = 3'(SNOOZE_MAX);

  state_t        state, state_n;
  logic [2:0]    snooze_left_n;
  logic          match, match_d, trig, set_ok;
  logic          load, expire;
  logic [TW-1:0] load_val;

  assign match  = (hh == alarm_hh) && (mm == alarm_mm) && (pm == alarm_pm) && (ss == BCD_00);
  assign trig   = match && !match_d;
  assign set_ok = set_en && bcd_time_valid(set_hh, set_mm);

  clock_alarm_ctrl_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .run      (state != ST_IDLE),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // Disarm and a valid alarm write outrank everything; an invalid write
  // falls through so it cannot cancel an active ring.
  always_comb begin
    state_n       = state;
    snooze_left_n = snooze_left;
    load          = 1'b0;
    load_val      = RING_LOAD;
    if (!arm || set_ok) begin
      state_n       = ST_IDLE;
      snooze_left_n = SNZ_RELOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            state_n = ST_RINGING;
            load    = 1'b1;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_n       = ST_IDLE;
            snooze_left_n = SNZ_RELOAD;
          end else if (snooze && (snooze_left != 3'd0)) begin
            state_n       = ST_SNOOZE;
            load          = 1'b1;
            load_val      = SNOOZE_LOAD;
            snooze_left_n = snooze_left - 3'd1;
          end else if (expire) begin
            state_n       = ST_IDLE;
            snooze_left_n = SNZ_RELOAD;
          end
        end
        ST_SNOOZE: begin
          if (dismiss) begin
            state_n       = ST_IDLE;
            snooze_left_n = SNZ_RELOAD;
          end else if (expire) begin
            state_n = ST_RINGING;
            load    = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      buzzer      <= 1'b0;
      snoozing    <= 1'b0;
      alarm_hh    <= BCD_12;
      alarm_mm    <= BCD_00;
      alarm_pm    <= 1'b0;
      snooze_left <= SNZ_RELOAD;
      match_d     <= 1'b0;
    end else begin
      state       <= state_n;
      buzzer      <= (state_n == ST_RINGING);
      snoozing    <= (state_n == ST_SNOOZE);
      snooze_left <= snooze_left_n;
      match_d     <= match;
      if (set_ok) begin
        alarm_hh <= set_hh;
        alarm_mm <= set_mm;
        alarm_pm <= set_pm;
      end
    end
  end

endmodule
